// File: rtl/alu_pkg.sv
// alu_seq shared definitions: opcodes, FSM states, flag bit positions.
// Build option: ALU_MUL_EN enables the multi-cycle unsigned multiply.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_NOTB = 3'b010;
  localparam logic [2:0] OP_CLR  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq request/result bundle; master issues ops, slave is the ALU.
// Build option: ALU_MUL_EN (no effect on the port list).
interface alu_seq_if #(parameter int W = 8);
  logic         start;
  logic [2:0]   Control;
  logic [W-1:0] DATA_A;
  logic [W-1:0] DATA_B;
  logic         busy;
  logic         done;
  logic [W-1:0] Result;
  logic [W-1:0] ResultHi;
  logic [3:0]   Flags;

  modport master (
    output start, Control, DATA_A, DATA_B,
    input  busy, done, Result, ResultHi, Flags
  );

  modport slave (
    input  start, Control, DATA_A, DATA_B,
    output busy, done, Result, ResultHi, Flags
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier, one partial product per step.
// o_prod is the product including the current step's partial product.
module alu_mul_seq #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_load,
  input  logic           i_step,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic [2*W-1:0] o_prod,
  output logic           o_last
);
  localparam int CW = $clog2(W);

  logic [2*W-1:0] r_acc;
  logic [2*W-1:0] r_mcand;
  logic [W-1:0]   r_mplr;
  logic [CW-1:0]  r_cnt;
  logic [2*W-1:0] w_nxt;

  assign w_nxt  = r_acc + (r_mplr[0] ? r_mcand : '0);
  assign o_prod = w_nxt;
  assign o_last = (r_cnt == CW'(W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc   <= '0;
      r_mcand <= '0;
      r_mplr  <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_acc   <= '0;
      r_mcand <= {{W{1'b0}}, i_a};
      r_mplr  <= i_b;
      r_cnt   <= '0;
    end else if (i_step) begin
      r_acc   <= w_nxt;
      r_mcand <= r_mcand << 1;
      r_mplr  <= r_mplr >> 1;
      r_cnt   <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered W-bit ALU with start/done handshake and NZCV flags.
// Build option: ALU_MUL_EN adds opcode 111 as W-cycle unsigned multiply.
module alu_seq
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input logic     clk,
  input logic     rst,
  alu_seq_if.slave bus
);
  state_t       r_state;
  state_t       w_next;
  logic         w_accept;
  logic         w_write;
  logic [2:0]   r_op;
  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic [W-1:0] r_res;
  logic [3:0]   r_flags;
  logic         r_done;
  logic [W:0]   w_sum;
  logic [W-1:0] w_res;
  logic         w_c;
  logic         w_v;
  logic [3:0]   w_eflags;

`ifdef ALU_MUL_EN
  logic [W-1:0]   r_hi;
  logic [2*W-1:0] w_prod;
  logic           w_mul_last;
  logic [3:0]     w_mflags;

  alu_mul_seq #(.W(W)) u_mul (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_accept),
    .i_step (r_state == S_MUL),
    .i_a    (bus.DATA_A),
    .i_b    (bus.DATA_B),
    .o_prod (w_prod),
    .o_last (w_mul_last)
  );

  always_comb begin
    w_mflags         = '0;
    w_mflags[FLAG_Z] = (w_prod == '0);
    w_mflags[FLAG_C] = |w_prod[2*W-1:W];
  end

  assign bus.ResultHi = r_hi;
`else
  assign bus.ResultHi = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_write  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          w_next   = S_EXEC;
`ifdef ALU_MUL_EN
          if (bus.Control == OP_MUL) w_next = S_MUL;
`endif
        end
      end
      S_EXEC: begin
        w_write = 1'b1;
        w_next  = S_IDLE;
      end
`ifdef ALU_MUL_EN
      S_MUL: begin
        if (w_mul_last) begin
          w_write = 1'b1;
          w_next  = S_IDLE;
        end
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  // Carry and overflow come from a W+1 bit sum; SUB adds ~B plus one.
  always_comb begin
    w_sum = '0;
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_sum = {1'b0, r_a} + {1'b0, r_b};
        w_res = w_sum[W-1:0];
        w_c   = w_sum[W];
        w_v   = (r_a[W-1] == r_b[W-1]) &&
                (w_sum[W-1] != r_a[W-1]);
      end
      OP_SUB: begin
        w_sum = {1'b0, r_a} + {1'b0, ~r_b}
              + {{W{1'b0}}, 1'b1};
        w_res = w_sum[W-1:0];
        w_c   = w_sum[W];
        w_v   = (r_a[W-1] == ~r_b[W-1]) &&
                (w_sum[W-1] != r_a[W-1]);
      end
      OP_NOTB:        w_res = ~r_b;
      OP_CLR, OP_MUL: w_res = '0;
      OP_AND:         w_res = r_a & r_b;
      OP_OR:          w_res = r_a | r_b;
      OP_XOR:         w_res = r_a ^ r_b;
      default:        w_res = '0;
    endcase
  end

  always_comb begin
    w_eflags         = '0;
    w_eflags[FLAG_N] = w_res[W-1];
    w_eflags[FLAG_Z] = (w_res == '0);
    w_eflags[FLAG_C] = w_c;
    w_eflags[FLAG_V] = w_v;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_flags <= '0;
      r_done  <= 1'b0;
`ifdef ALU_MUL_EN
      r_hi    <= '0;
`endif
    end else begin
      r_done <= w_write;
      if (w_accept) begin
        r_op <= bus.Control;
        r_a  <= bus.DATA_A;
        r_b  <= bus.DATA_B;
      end
      if (w_write) begin
        if (r_state == S_EXEC) begin
          r_res   <= w_res;
          r_flags <= w_eflags;
`ifdef ALU_MUL_EN
          r_hi    <= '0;
        end else begin
          r_res   <= w_prod[W-1:0];
          r_hi    <= w_prod[2*W-1:W];
          r_flags <= w_mflags;
`endif
        end
      end
    end
  end

  assign bus.busy   = (r_state != S_IDLE);
  assign bus.done   = r_done;
  assign bus.Result = r_res;
  assign bus.Flags  = r_flags;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (W=8) against an arithmetic model.
// Build option: ALU_MUL_EN selects the multiply-enabled expectations.
module tb_alu_seq;
  localparam int W = 8;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_seq_if #(.W(W)) bus ();

  alu_seq #(.W(W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [19:0] last_e;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h",
             tag, obs, exp);
    end
  endtask

  function automatic int sx(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  // Returns {ResultHi, Result, N, Z, C, V}.
  function automatic logic [19:0] model(input int op,
                                        input int a,
                                        input int b);
    int r, hi, n, z, c, v, s;
    r = 0; hi = 0; n = 0; z = 0; c = 0; v = 0;
    case (op)
      0: begin
        r = a + b;
        c = (r > 255) ? 1 : 0;
        s = sx(a) + sx(b);
        v = (s > 127 || s < -128) ? 1 : 0;
      end
      1: begin
        r = a - b;
        c = (a >= b) ? 1 : 0;
        s = sx(a) - sx(b);
        v = (s > 127 || s < -128) ? 1 : 0;
      end
      2: r = 255 - b;
      3: r = 0;
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      default: begin
        if (MUL_EN) begin
          r  = a * b;
          hi = r / 256;
          r  = r % 256;
        end else r = 0;
      end
    endcase
    r = r & 255;
    if (op == 7 && MUL_EN) begin
      z = (r == 0 && hi == 0) ? 1 : 0;
      c = (hi != 0) ? 1 : 0;
    end else begin
      n = (r >= 128) ? 1 : 0;
      z = (r == 0) ? 1 : 0;
    end
    return {8'(hi), 8'(r), 1'(n), 1'(z), 1'(c), 1'(v)};
  endfunction

  task automatic run_op(input int op, input int a, input int b,
                        input bit poke, input string tag);
    logic [19:0] e;
    int lat, exp_lat;
    e       = model(op, a, b);
    exp_lat = (op == 7 && MUL_EN) ? W : 1;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.Control = 3'(op);
    bus.DATA_A  = 8'(a);
    bus.DATA_B  = 8'(b);
    @(posedge clk); #1;
    chk({tag, ".acc_busy"}, 32'(bus.busy), 1);
    chk({tag, ".acc_done"}, 32'(bus.done), 0);
    bus.start   = poke;
    bus.Control = 3'($urandom);
    bus.DATA_A  = 8'($urandom);
    bus.DATA_B  = 8'($urandom);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (!bus.done) begin
        chk({tag, ".busy"}, 32'(bus.busy), 1);
        bus.start   = poke;
        bus.DATA_A  = 8'($urandom);
        bus.DATA_B  = 8'($urandom);
      end
    end while (!bus.done && lat < 40);
    bus.start = 1'b0;
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".result"}, 32'(bus.Result), 32'(e[11:4]));
    chk({tag, ".resulthi"}, 32'(bus.ResultHi), 32'(e[19:12]));
    chk({tag, ".flags"}, 32'(bus.Flags), 32'(e[3:0]));
    chk({tag, ".idle"}, 32'(bus.busy), 0);
    last_e = e;
  endtask

  task automatic hold_chk(input string tag);
    @(posedge clk); #1;
    chk({tag, ".hold_done"}, 32'(bus.done), 0);
    chk({tag, ".hold_res"}, 32'(bus.Result), 32'(last_e[11:4]));
    chk({tag, ".hold_flags"}, 32'(bus.Flags), 32'(last_e[3:0]));
  endtask

  task automatic reset_mid(input int op, input int edges,
                           input string tag);
    int dn;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.Control = 3'(op);
    bus.DATA_A  = 8'hA5;
    bus.DATA_B  = 8'h5A;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (edges) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk({tag, ".rst_res"}, 32'(bus.Result), 0);
    chk({tag, ".rst_hi"}, 32'(bus.ResultHi), 0);
    chk({tag, ".rst_flags"}, 32'(bus.Flags), 0);
    chk({tag, ".rst_busy"}, 32'(bus.busy), 0);
    chk({tag, ".rst_done"}, 32'(bus.done), 0);
    @(negedge clk);
    rst = 1'b0;
    dn = 0;
    repeat (W + 2) begin
      @(posedge clk); #1;
      if (bus.done) dn++;
    end
    chk({tag, ".no_done"}, 32'(dn), 0);
    last_e = '0;
  endtask

  initial begin
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.Control = '0;
    bus.DATA_A  = '0;
    bus.DATA_B  = '0;
    last_e      = '0;
    #12;
    chk("reset.busy", 32'(bus.busy), 0);
    chk("reset.done", 32'(bus.done), 0);
    chk("reset.res", 32'(bus.Result), 0);
    chk("reset.hi", 32'(bus.ResultHi), 0);
    chk("reset.flags", 32'(bus.Flags), 0);
    @(negedge clk);
    rst = 1'b0;

    run_op(0, 8'h7F, 8'h01, 1'b0, "add_ovf");
    chk("add_ovf.flags_lit", 32'(bus.Flags), 32'h9);
    hold_chk("add_ovf");
    run_op(1, 8'h05, 8'h05, 1'b0, "sub_zero");
    chk("sub_zero.flags_lit", 32'(bus.Flags), 32'h6);
    run_op(1, 8'h00, 8'h01, 1'b0, "sub_borrow");
    chk("sub_borrow.flags_lit", 32'(bus.Flags), 32'h8);
    run_op(1, 8'h80, 8'h01, 1'b0, "sub_ovf");
    run_op(2, 8'h00, 8'h0F, 1'b0, "notb");
    run_op(3, 8'h12, 8'h34, 1'b1, "clr");
    run_op(4, 8'hCC, 8'hAA, 1'b0, "and");
    run_op(5, 8'hCC, 8'hAA, 1'b0, "or");
    run_op(6, 8'hCC, 8'hAA, 1'b0, "xor");
    hold_chk("xor");
    run_op(7, 8'h12, 8'h34, 1'b0, "op7");
`ifdef ALU_MUL_EN
    run_op(7, 8'hFF, 8'hFF, 1'b1, "mul_ff");
    chk("mul_ff.hi_lit", 32'(bus.ResultHi), 32'hFE);
    hold_chk("mul_ff");
    run_op(0, 8'h40, 8'h41, 1'b0, "pre_rst");
    reset_mid(7, 3, "rst_mul");
`else
    run_op(0, 8'h40, 8'h41, 1'b0, "pre_rst");
    reset_mid(0, 0, "rst_exec");
`endif
    run_op(0, 8'h02, 8'h03, 1'b0, "add_after_rst");

    for (int i = 0; i < 40; i++) begin
      run_op(int'($urandom_range(0, 7)),
             int'($urandom_range(0, 255)),
             int'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), "rand");
      if ($urandom_range(0, 3) == 0) hold_chk("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Registered, parametrised successor to the team's 4-bit combinational ALU. It accepts an operation through a start/done handshake and latches its operands on accept. It drives a registered result with status flags, and optionally runs a multi-cycle unsigned shift-add multiply. It sits between the lab datapath register file and the result bus, wherever a W-bit arithmetic unit with flags and a busy indication is required.

## Interface
- W, default 8, operand/result width (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only while idle
- Control  input  3  opcode
- DATA_A  input  W  operand A
- DATA_B  input  W  operand B
- busy  output  1  high while an accepted operation is in progress
- done  output  1  one-cycle pulse: Result/ResultHi/Flags updated this cycle
- Result  output  W  result, low half for MUL
- ResultHi  output  W  MUL high half; 0 for all other ops
- Flags  output  4  {N, Z, C, V}

## Operation
- Opcodes:
  - 000 ADD: A+B
  - 001 SUB: A+~B+1
  - 010 NOTB: ~B
  - 011 CLR: 0
  - 100 AND
  - 101 OR
  - 110 XOR
  - 111 MUL: unsigned A×B, only when compiled in
- States: IDLE, EXEC, MUL.
  - IDLE with start=1: latch Control, DATA_A, DATA_B. Go to MUL if the opcode is 111 and MUL is enabled; otherwise go to EXEC.
  - EXEC: write outputs, pulse done, return to IDLE.
  - MUL: W shift-add iterations. On the last one, write outputs, pulse done, return to IDLE.
- busy = (state != IDLE). start while busy is ignored; it is not queued.
- Operand inputs are don't-care after accept.
- ADD and SUB are computed at W+1 bits:
  - C = bit W of the sum. For SUB, C=1 means no borrow.
  - V = signed overflow: operand signs equal (for SUB, A and ~B) and the result sign differs.
- NOTB, CLR, AND, OR, XOR: C=0, V=0.
- All non-MUL ops: N=Result[W-1], Z=(Result==0), ResultHi=0.
- MUL flags: {ResultHi, Result} = 2W-bit product; Z=(product==0), N=0, C=(ResultHi!=0), V=0.
- Result, ResultHi and Flags hold their values between done pulses.

## Timing
- Reset state (asynchronous): state=IDLE; busy=0, done=0, Result=0, ResultHi=0, Flags=0; multiplier internals cleared.
- Non-MUL latency:
  - start accepted at edge n → busy high after n.
  - Outputs and done=1 after edge n+1; busy low after n+1.
- MUL latency:
  - accepted at edge n → busy high for W cycles.
  - Outputs and done=1 after edge n+W.
- Back-to-back issue: start may be asserted in the cycle done is high, since state is IDLE. The next accept is then at the edge that ends the done cycle. Maximum throughput is one non-MUL op per 2 cycles.
- Reset mid-operation: the operation is aborted with no done pulse, and outputs return to 0.
- A start with an illegal or disabled opcode is never rejected; it is decoded per Configuration.

## Configuration
- ALU_MUL_EN defined: opcode 111 = multi-cycle MUL as above; alu_mul_seq is instantiated.
- ALU_MUL_EN undefined:
  - Opcode 111 behaves as CLR (EXEC path, 1-cycle latency, Result=0, Z=1).
  - MUL state and alu_mul_seq are absent.
  - ResultHi is tied to 0; the port remains.

## Structure
- Package alu_pkg:
  - opcode localparams OP_ADD…OP_MUL
  - state encoding (IDLE, EXEC, MUL)
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
- Sub-module alu_mul_seq (W parameter):
  - load/step interface
  - shift-add, one partial product per cycle
  - exposes a 2W-bit product and a last-step indication
- Top-level alu_seq: FSM, operand latches, combinational single-cycle op decode, output registers.

## Test plan
- W=8, ADD A=0x7F, B=0x01 → Result=0x80, Flags N=1 Z=0 C=0 V=1. done exactly 1 cycle after accept; busy high for 1 cycle.
- SUB 0x05−0x05 → Result=0x00, Z=1 C=1 V=0. Then SUB 0x00−0x01 → 0xFF, N=1 C=0 V=0. Then SUB 0x80−0x01 → 0x7F, V=1.
- NOTB B=0x0F → 0xF0, N=1. CLR → 0x00, Z=1. AND/OR/XOR A=0xCC, B=0xAA → 0x88 / 0xEE / 0x66, with C=V=0.
- ALU_MUL_EN: MUL 0xFF×0xFF → ResultHi=0xFE, Result=0x01, C=1 Z=0.
  - done exactly 8 edges after accept.
  - A start pulse with changed operands mid-MUL is ignored and the result is unchanged.
- Reset asserted asynchronously during the 4th MUL cycle → all outputs 0 immediately, no done. A following ADD 0x02+0x03 → 0x05 with normal latency.
- Without ALU_MUL_EN: opcode 111, A=0x12, B=0x34 → Result=0x00, ResultHi=0x00, Z=1, done 1 cycle after accept.
